// File: rtl/vx_rsp_demux_pkg.sv
// Shared types and constants for the response demultiplexer.
// The optional stall counter is enabled by defining RSP_DEMUX_PERF_EN.
package vx_rsp_demux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/vx_rsp_demux_slot.sv
// Two-entry elastic slot: a registered output stage plus a skid register,
// so that the producer can run at full rate with no combinational ready path.
module vx_rsp_demux_slot
    import vx_rsp_demux_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DATAW-1:0] push_data,
    output logic             full,
    output logic             valid,
    output logic [DATAW-1:0] data,
    input  logic             ready
);

    slot_state_e      state;
    logic [DATAW-1:0] skid;
    logic             pop;

    assign valid = (state != EMPTY);
    assign full  = (state == FULL);
    assign pop   = valid && ready;

    // NOTE: state and payload registers use non-blocking assignments so every
    // register samples the pre-edge values; blocking here would create
    // order-dependent races between the output stage and the skid.
    // NOTE: the payload registers are reset as well because the output slice
    // must read zero after reset, not whatever was left over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            data  <= '0;
            skid  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        state <= ONE;
                        data  <= push_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        data <= push_data;
                    end else if (push) begin
                        skid  <= push_data;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // The top never pushes a FULL slot, so only a pop can move it.
                    if (pop) begin
                        data  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/vx_rsp_demux.sv
// Routes a tagged response stream back to NUM_REQS requesters, one elastic
// slot each. Defining RSP_DEMUX_PERF_EN adds the perf_stalls counter port.
module vx_rsp_demux
    import vx_rsp_demux_pkg::*;
#(
    parameter int NUM_REQS     = 4,
    parameter int DATAW        = 32,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [DATAW-1:0]          data_in,
    input  logic [LOG_NUM_REQS-1:0]   sel_in,
    output logic                      ready_in,
    output logic [NUM_REQS-1:0]       valid_out,
    output logic [NUM_REQS*DATAW-1:0] data_out,
    input  logic [NUM_REQS-1:0]       ready_out
`ifdef RSP_DEMUX_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]     perf_stalls
`endif
);

    logic [NUM_REQS-1:0] hit;
    logic [NUM_REQS-1:0] full;
    logic [NUM_REQS-1:0] push;
    logic                sel_ok;
    logic                fire_in;

    // NOTE: hit gets a full default before the loop so no bit is ever left
    // unassigned on some path, which would otherwise infer a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            hit[i] = (NUM_REQS == 1) || (sel_in == LOG_NUM_REQS'(i));
        end
    end

    // An out-of-range select hits no slot: ready stays high and the beat is dropped.
    assign sel_ok   = |hit;
    assign ready_in = ~|(hit & full);
    assign fire_in  = valid_in && ready_in;
    assign push     = hit & {NUM_REQS{fire_in}};

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_slot
        vx_rsp_demux_slot #(
            .DATAW (DATAW)
        ) slot (
            .clk       (clk),
            .reset     (reset),
            .push      (push[i]),
            .push_data (data_in),
            .full      (full[i]),
            .valid     (valid_out[i]),
            .data      (data_out[i*DATAW +: DATAW]),
            .ready     (ready_out[i])
        );
    end

    always @(posedge clk) begin
        if (!reset && valid_in) begin
            assert (sel_ok);
        end
    end

`ifdef RSP_DEMUX_PERF_EN
    logic [PERF_CNT_W-1:0] perf_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt <= '0;
        end else if (valid_in && !ready_in && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + PERF_CNT_W'(1);
        end
    end

    assign perf_stalls = perf_cnt;
`else
    // Without the perf option the stall condition is not observed at all.
`endif

endmodule

// File: tb/tb_vx_rsp_demux.sv
// Directed self-checking bench for vx_rsp_demux (NUM_REQS=4, DATAW=32).
// The perf_stalls checks are compiled only when RSP_DEMUX_PERF_EN is defined.
module tb_vx_rsp_demux;

    localparam int NUM_REQS = 4;
    localparam int DATAW    = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      valid_in;
    logic [DATAW-1:0]          data_in;
    logic [1:0]                sel_in;
    logic                      ready_in;
    logic [NUM_REQS-1:0]       valid_out;
    logic [NUM_REQS*DATAW-1:0] data_out;
    logic [NUM_REQS-1:0]       ready_out;
`ifdef RSP_DEMUX_PERF_EN
    logic [31:0]               perf_stalls;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_rsp_demux #(
        .NUM_REQS (NUM_REQS),
        .DATAW    (DATAW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .sel_in      (sel_in),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .ready_out   (ready_out)
`ifdef RSP_DEMUX_PERF_EN
        ,
        .perf_stalls (perf_stalls)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] slice(input int i);
        return data_out[i*DATAW +: DATAW];
    endfunction

    // Advance one clock and sample #1 after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [31:0] data);
        valid_in = 1'b1;
        sel_in   = sel;
        data_in  = data;
    endtask

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        sel_in    = '0;
        ready_out = '1;
        #1;
        check("reset_valid", 128'(valid_out), 128'h0);
        check("reset_data", data_out, 128'h0);
        check("reset_ready", 128'(ready_in), 128'h1);
        tick();
        tick();
        reset = 1'b0;

        // Basic routing
        send(2'd2, 32'hA5);
        #1;
        check("basic_ready_pre", 128'(ready_in), 128'h1);
        tick();
        check("basic_valid", 128'(valid_out), 128'h4);
        check("basic_data", 128'(slice(2)), 128'hA5);
        check("basic_ready_post", 128'(ready_in), 128'h1);
        valid_in = 1'b0;
        tick();
        check("basic_drained", 128'(valid_out), 128'h0);

        // Full throughput: one beat per cycle, sel cycling 0..3
        for (int k = 0; k < 16; k++) begin
            send(2'(k % 4), 32'h100 + 32'(k));
            #1;
            check($sformatf("thru_ready_%0d", k), 128'(ready_in), 128'h1);
            tick();
            check($sformatf("thru_valid_%0d", k), 128'(valid_out), 128'(1 << (k % 4)));
            check($sformatf("thru_data_%0d", k), 128'(slice(k % 4)), 128'(32'h100 + 32'(k)));
        end
        valid_in = 1'b0;
        tick();
        check("thru_drained", 128'(valid_out), 128'h0);

        // Backpressure on requester 1
        ready_out = 4'b1101;
        send(2'd1, 32'h11);
        #1;
        check("bp_ready_a", 128'(ready_in), 128'h1);
        tick();
        send(2'd1, 32'h22);
        #1;
        check("bp_ready_b", 128'(ready_in), 128'h1);
        tick();
        send(2'd1, 32'h33);
        #1;
        check("bp_ready_c_blocked", 128'(ready_in), 128'h0);
        check("bp_head_valid", 128'(valid_out), 128'h2);
        check("bp_head_data", 128'(slice(1)), 128'h11);

        // Isolation: requester 3 still served while slot 1 is full
        send(2'd3, 32'h44);
        #1;
        check("iso_ready", 128'(ready_in), 128'h1);
        tick();
        check("iso_valid", 128'(valid_out), 128'hA);
        check("iso_data", 128'(slice(3)), 128'h44);
        check("iso_slot1_hold", 128'(slice(1)), 128'h11);

        // Release requester 1: drain 0x11, then 0x22, then accept 0x33
        send(2'd1, 32'h33);
        ready_out = 4'b1111;
        #1;
        check("bp_still_blocked", 128'(ready_in), 128'h0);
        tick();
        check("bp_drain_valid", 128'(valid_out), 128'h2);
        check("bp_drain_data_b", 128'(slice(1)), 128'h22);
        check("bp_ready_c_open", 128'(ready_in), 128'h1);
        tick();
        check("bp_c_valid", 128'(valid_out), 128'h2);
        check("bp_c_data", 128'(slice(1)), 128'h33);
        valid_in = 1'b0;
        tick();
        check("bp_drained", 128'(valid_out), 128'h0);

        // Reset mid-operation with slots 0 and 2 full
        ready_out = 4'b0000;
        send(2'd0, 32'hA0);
        tick();
        send(2'd0, 32'hA1);
        tick();
        send(2'd2, 32'hB0);
        tick();
        send(2'd2, 32'hB1);
        tick();
        valid_in = 1'b0;
        sel_in   = 2'd0;
        #1;
        check("mid_valid", 128'(valid_out), 128'h5);
        check("mid_full0", 128'(ready_in), 128'h0);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_valid", 128'(valid_out), 128'h0);
        check("async_reset_data", data_out, 128'h0);
        #1;
        reset     = 1'b0;
        ready_out = 4'b1111;
        tick();
        send(2'd0, 32'hC0);
        tick();
        check("post_reset_valid", 128'(valid_out), 128'h1);
        check("post_reset_data0", 128'(slice(0)), 128'hC0);
        check("post_reset_data2", 128'(slice(2)), 128'h0);
        valid_in = 1'b0;
        tick();

`ifdef RSP_DEMUX_PERF_EN
        reset = 1'b1;
        #1;
        reset = 1'b0;
        check("perf_reset", 128'(perf_stalls), 128'h0);
        ready_out = 4'b0000;
        send(2'd0, 32'hD0);
        tick();
        send(2'd0, 32'hD1);
        tick();
        send(2'd0, 32'hD2);
        for (int k = 0; k < 7; k++) tick();
        check("perf_seven", 128'(perf_stalls), 128'h7);
        valid_in = 1'b0;
        dut.perf_cnt = 32'hFFFF_FFFE;
        #1;
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("perf_saturate", 128'(perf_stalls), 128'hFFFF_FFFF);
        valid_in = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
